// File: rtl/uart_rx_byte_if.sv
// ============================================================================
// Module      : uart_rx_byte_if
// Description : Serial line and received-byte signals between the radio RX
//               line, the UART receiver and the game logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_byte_if;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_err;
    logic       busy;

    // Consumer side: drives the serial line, observes the decoded byte.
    modport master (
        output rx,
        input  data_out,
        input  data_valid,
        input  framing_err,
        input  busy
    );

    // Receiver side.
    modport slave (
        input  rx,
        output data_out,
        output data_valid,
        output framing_err,
        output busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx_byte.sv
// ============================================================================
// Module      : uart_rx_byte
// Description : 8N1 UART receiver with a two-flop synchroniser, one-cycle
//               data_valid / framing_err strobes and break-guard state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 1042
) (
    input  wire logic     clk,
    input  wire logic     Rst,
    uart_rx_byte_if.slave bus
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] c_HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] c_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      data_q, data_d;
    logic            data_valid_q, data_valid_d;
    logic            framing_err_q, framing_err_d;
    logic            rx_meta_q;
    logic            rx_s_q;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk) begin
        if (Rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q       <= S_IDLE;
            clk_cnt_q     <= '0;
            bit_idx_q     <= '0;
            shreg_q       <= '0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clk_cnt_q     <= clk_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shreg_q       <= shreg_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            framing_err_q <= framing_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        clk_cnt_d     = clk_cnt_q;
        bit_idx_d     = bit_idx_q;
        shreg_d       = shreg_q;
        data_d        = data_q;
        data_valid_d  = 1'b0;
        framing_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (clk_cnt_q == c_HALF_LAST) begin
                    clk_cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + c_CNT_ONE;
                end
            end

            S_DATA: begin
                if (clk_cnt_q == c_BIT_LAST) begin
                    clk_cnt_d = '0;
                    shreg_d   = {rx_s_q, shreg_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + c_CNT_ONE;
                end
            end

            S_STOP: begin
                if (clk_cnt_q == c_BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s_q) begin
                        data_d       = shreg_q;
                        data_valid_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        framing_err_d = 1'b1;
                        state_d       = S_WAIT_HIGH;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + c_CNT_ONE;
                end
            end

            // A held-low line (break) must not be mistaken for a new start bit.
            S_WAIT_HIGH: begin
                clk_cnt_d = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d   = S_IDLE;
                clk_cnt_d = '0;
            end
        endcase
    end

    assign bus.data_out    = data_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.framing_err = framing_err_q;
    assign bus.busy        = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Serial receiver for the wireless link between the host and player boards.
- Recovers 8N1 UART frames (1 start, 8 data LSB-first, 1 stop, no parity) from the radio module's RX line.
- Delivers each byte (ASCII letter or control code) with a one-cycle valid strobe to the game logic.
- Receive end of the path whose transmit side raises msg_sent.

Parameters:
- CLKS_PER_BIT, 1042, system clocks per UART bit (10 MHz / 9600 baud). Legal range ≥ 4.
- HALF_BIT, CLKS_PER_BIT/2 (integer division), clocks from detected start edge to mid-start sample. Derived; not overridden.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- Rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- data_out  output  8  last correctly framed byte.
- data_valid  output  1  one-cycle pulse: data_out just updated.
- framing_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (Rst=1 at rising edge):
  - state=IDLE; data_out=8'h00; data_valid=0; framing_err=0; busy=0.
  - Sync flops=1; bit counter, bit index and shift register cleared.
  - Reset applies in every state, including mid-frame; the partial byte is discarded with no pulse.
- Synchroniser: rx passes through two flops, producing rx_s. All decisions use rx_s, so rx_s lags rx by 2 cycles.
- Clock counter: clk_cnt increments every cycle while in START, DATA or STOP. It clears on each state or bit transition. Width is $clog2(CLKS_PER_BIT).
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - rx_s=0 → START, clk_cnt=0.
  - Otherwise stay.
- START:
  - At clk_cnt=HALF_BIT-1, sample rx_s.
  - rx_s=0 → DATA, bit_idx=0, clk_cnt=0.
  - rx_s=1 → IDLE. This is a glitch: no pulse, no error.
- DATA:
  - At clk_cnt=CLKS_PER_BIT-1, shift right: shreg <= {rx_s, shreg[7:1]}.
  - If bit_idx=7 → STOP; otherwise bit_idx+1. clk_cnt clears in both cases.
- STOP:
  - At clk_cnt=CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1: data_out<=shreg, data_valid=1 for exactly one cycle, → IDLE.
  - rx_s=0: framing_err=1 for exactly one cycle, data_out unchanged, → WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rx_s=1, then → IDLE. This prevents a break condition from being decoded as a new start bit.
- Latency: data_valid is high on the cycle after the stop sample, i.e. HALF_BIT + 9·CLKS_PER_BIT + 1 cycles after the first cycle rx_s=0 is registered in IDLE.
- Outputs:
  - data_valid and framing_err are registered and mutually exclusive; they never assert while Rst=1.
  - data_out holds its value until the next good frame.
- Back-to-back frames: a start bit immediately after the stop bit is caught. The FSM returns to IDLE at mid-stop, so half a bit of margin remains.
- No buffering: the consumer must take data_out on the data_valid cycle or before the next frame completes. Later bytes overwrite data_out.

Test Plan (CLKS_PER_BIT=8, HALF_BIT=4):
- After reset, rx held high for 50 cycles → data_out=8'h00, data_valid=0, framing_err=0, busy=0 throughout.
- Send frame 8'h41 ('A') → exactly one data_valid pulse with data_out=8'h41, no framing_err, busy=0 on the following cycle.
- Send 8'h50, 8'h50, 8'h4C ('P','P','L') back-to-back with no idle gap → three data_valid pulses, 8·10 cycles apart, data_out 8'h50, 8'h50, 8'h4C respectively.
- Drive rx low for 2 cycles, then high → busy pulses high, returns to IDLE within HALF_BIT+3 cycles, no data_valid, no framing_err.
- Send 8'h45 with stop bit 0, then hold rx low for 20 cycles, then high → one framing_err pulse, no data_valid, data_out retains its previous value, busy stays high until rx_s=1. A subsequent valid 8'h45 frame is received correctly.
- Assert Rst for 1 cycle in the middle of data bit 4 of a frame → all outputs at reset values the next cycle, no pulse for the aborted frame. The next full frame 8'h5A yields data_out=8'h5A.
